// File: rtl/hub75_rx_capture.sv
// HUB75 panel-side receiver: captures the row-scan stream and rebuilds the image in a 2*ROWS x COLS x RGB frame buffer.
// Optional macro HUB75_RX_SCLK_EN adds an external sclk input that qualifies shifts instead of every clk cycle.
module hub75_rx_capture #(
  parameter int COLS = 64,
  parameter int ROWS = 16,
  parameter int AW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     A,
  input  logic                     B,
  input  logic                     C,
  input  logic                     D,
  input  logic                     R0,
  input  logic                     G0,
  input  logic                     B0,
  input  logic                     R1,
  input  logic                     G1,
  input  logic                     B1,
  input  logic                     OE,
  input  logic                     LAT,
`ifdef HUB75_RX_SCLK_EN
  input  logic                     sclk,
`endif
  input  logic [$clog2(COLS)-1:0]  rd_x,
  input  logic [AW:0]              rd_y,
  output logic [2:0]               rd_rgb,
  output logic                     row_done,
  output logic                     frame_done,
  output logic                     len_err,
  output logic                     abort,
  output logic [AW-1:0]            last_row
);

  localparam int CW    = $clog2(COLS);
  localparam int LINES = 2 * ROWS;
  localparam logic [CW:0]   COL_FULL = (CW+1)'(COLS);
  localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [11:0]   in_vec;
  logic [11:0]   in_dly;
  logic          shift_edge;
  logic          oe_s, lat_s, shift_en;
  logic [3:0]    row_full;
  logic [AW-1:0] row_s;
  logic [2:0]    px_hi, px_lo;

  assign in_vec = {OE, LAT, D, C, B, A, R0, G0, B0, R1, G1, B1};

`ifdef HUB75_RX_SCLK_EN
  // sclk goes through a 2-flop synchroniser; the third bit is the previous synchronised value for edge detect.
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [11:0] dly1_q, dly1_d, dly2_q, dly2_d;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    dly1_d      = in_vec;
    dly2_d      = dly1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      dly1_q      <= '0;
      dly2_q      <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      dly1_q      <= dly1_d;
      dly2_q      <= dly2_d;
    end
  end

  assign in_dly     = dly2_q;
  assign shift_edge = sclk_sync_q[1] & ~sclk_sync_q[2];
`else
  assign in_dly     = in_vec;
  assign shift_edge = 1'b1;
`endif

  assign oe_s     = in_dly[11];
  assign lat_s    = in_dly[10];
  assign row_full = in_dly[9:6];
  assign row_s    = row_full[AW-1:0];
  assign px_hi    = in_dly[5:3];
  assign px_lo    = in_dly[2:0];
  assign shift_en = shift_edge & oe_s & ~lat_s;

  logic [2:0] upper_mem [COLS];
  logic [2:0] lower_mem [COLS];
  logic [2:0] fb_mem    [LINES][COLS];

  state_t        state_q, state_d;
  logic [CW:0]   col_cnt_q, col_cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] commit_row_q, commit_row_d;
  logic [AW-1:0] last_row_q, last_row_d;
  logic          row_done_q, row_done_d;
  logic          frame_done_q, frame_done_d;
  logic          len_err_q, len_err_d;
  logic          abort_q, abort_d;
  logic [2:0]    rd_rgb_q, rd_rgb_d;
  logic          cap_en, commit_we;

  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    ovf_d        = ovf_q;
    commit_row_d = commit_row_q;
    last_row_d   = last_row_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    len_err_d    = 1'b0;
    abort_d      = 1'b0;
    cap_en       = 1'b0;
    commit_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // LAT here with no shifts becomes a zero-length row and ends in len_err.
        if (lat_s) begin
          state_d      = COMMIT;
          commit_row_d = row_s;
        end else if (shift_en) begin
          state_d = SHIFT;
          cap_en  = 1'b1;
        end
      end
      SHIFT: begin
        if (lat_s) begin
          state_d      = COMMIT;
          commit_row_d = row_s;
        end else if (shift_en) begin
          cap_en = 1'b1;
        end else if (!oe_s) begin
          abort_d   = 1'b1;
          col_cnt_d = '0;
          ovf_d     = 1'b0;
          state_d   = IDLE;
        end
      end
      COMMIT: begin
        if (col_cnt_q == COL_FULL && !ovf_q) begin
          commit_we    = 1'b1;
          row_done_d   = 1'b1;
          last_row_d   = commit_row_q;
          frame_done_d = (commit_row_q == ROW_LAST);
        end else begin
          len_err_d = 1'b1;
        end
        col_cnt_d = '0;
        ovf_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cap_en) begin
      if (col_cnt_q == COL_FULL) ovf_d = 1'b1;
      else                       col_cnt_d = col_cnt_q + (CW+1)'(1);
    end

    rd_rgb_d = (32'(rd_y) < 32'(LINES)) ? fb_mem[rd_y][rd_x] : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      commit_row_q <= '0;
      last_row_q   <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      abort_q      <= 1'b0;
      rd_rgb_q     <= '0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      ovf_q        <= ovf_d;
      commit_row_q <= commit_row_d;
      last_row_q   <= last_row_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
      abort_q      <= abort_d;
      rd_rgb_q     <= rd_rgb_d;
    end
  end

  // Line buffers and frame buffer carry no reset; committed lines survive a reset.
  always_ff @(posedge clk) begin
    if (rst && cap_en && col_cnt_q != COL_FULL) begin
      upper_mem[col_cnt_q[CW-1:0]] <= px_hi;
      lower_mem[col_cnt_q[CW-1:0]] <= px_lo;
    end
    if (rst && commit_we) begin
      for (int c = 0; c < COLS; c++) begin
        fb_mem[{1'b0, commit_row_q}][CW'(c)] <= upper_mem[CW'(c)];
        fb_mem[{1'b1, commit_row_q}][CW'(c)] <= lower_mem[CW'(c)];
      end
    end
  end

  assign rd_rgb     = rd_rgb_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;
  assign abort      = abort_q;
  assign last_row   = last_row_q;

endmodule

// File: doc/hub75_rx_capture.md
Name: hub75_rx_capture

Overview:
- Panel-side receiver for the HUB75 row-scan interface that our matrix driver produces.
- Samples the serial RGB column stream, row address and LAT/OE strobes.
- Rebuilds the displayed image in an internal 32x64x3 frame buffer; a host reads it through a random-access port.
- Used as an in-system loopback checker and as the input stage for a cascaded second panel.

Parameters:
- COLS, 64: pixels shifted per row pair; power of two, max 128.
- ROWS, 16: scan rows (row-address range); lines stored = 2*ROWS.
- AW, 4: row-address width, must equal log2(ROWS).

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- rst  in  1  reset, synchronous, active-low.
- A, B, C, D  in  1 each  row address, {D,C,B,A} = row, D is MSB.
- R0, G0, B0  in  1 each  upper-half pixel bits (line = row).
- R1, G1, B1  in  1 each  lower-half pixel bits (line = row + ROWS).
- OE  in  1  high = data phase.
- LAT  in  1  high = latch current row.
- rd_x  in  log2(COLS)  read column.
- rd_y  in  AW+1  read line, 0..2*ROWS-1.
- rd_rgb  out  3  {R,G,B} at (rd_x, rd_y).
- row_done  out  1  one-cycle pulse: row committed.
- frame_done  out  1  one-cycle pulse: row ROWS-1 committed.
- len_err  out  1  one-cycle pulse: latch with wrong column count.
- abort  out  1  one-cycle pulse: OE dropped before LAT.
- last_row  out  AW  address of last committed row.

Behaviour:
- Reset (rst=0 at a clk edge): FSM to IDLE; col_cnt, row_done, frame_done, len_err, abort, last_row and rd_rgb all 0. Frame buffer contents are not cleared.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: go to SHIFT when OE=1 && LAT=0. That same cycle is treated as a shift (column 0 captured).
  - SHIFT: each cycle with OE=1 && LAT=0, store {R0,G0,B0} at upper line-buffer index col_cnt and {R1,G1,B1} at lower index col_cnt, then col_cnt++.
    - col_cnt saturates at COLS; extra shifts are dropped but keep the overflow visible as col_cnt==COLS plus a sticky ovf bit.
    - LAT=1 (OE any): go to COMMIT; register {D,C,B,A} this cycle as the commit row.
    - OE=0 && LAT=0: pulse abort, clear col_cnt, go to IDLE; nothing is written.
  - COMMIT (one cycle):
    - If col_cnt==COLS and ovf=0: write upper line buffer to frame line row and lower to line row+ROWS, as a whole-line write. Pulse row_done next cycle, update last_row, pulse frame_done too if row==ROWS-1.
    - Otherwise: no write; pulse len_err.
    - In both cases clear col_cnt and ovf, then go to IDLE.
- LAT seen in IDLE with no preceding shift: treated as a zero-length row, so len_err pulses.
- Shift and LAT in the same cycle: LAT wins and no column is captured.
- Pulse timing: all pulses are registered, asserted the cycle after COMMIT (or after the abort detect), and last exactly one cycle.
- Read port: rd_rgb is registered, 1-cycle latency from rd_x/rd_y.
  - rd_y >= 2*ROWS returns 0.
  - Reading a line in the same cycle it is committed returns the old data; new data is visible the following cycle.
- Row address wraps naturally: row 15 followed by row 0 is legal and needs no special case.
- Reset mid-SHIFT discards the partial row; already committed lines stay intact.
- Minimum legal row timing: 1 IDLE-entry shift cycle + COLS-1 shifts + 1 LAT cycle.

Optional Feature:
- Macro: HUB75_RX_SCLK_EN.
- Defined: adds input port sclk (1 bit), carried by external panels.
  - sclk is synchronised through two flops; a shift occurs only on a detected synchronised rising edge with OE=1 && LAT=0.
  - Pixel and address inputs are delayed by 2 flops to stay aligned with the synchronised sclk.
  - LAT is also delayed by 2 flops.
- Not defined: no sclk port; every clk cycle with OE=1 && LAT=0 is a shift, as described above.

Test Plan:
- Single row: rst low 2 cycles, then OE=1/LAT=0 for 64 cycles with upper pixel = col[0] ? 3'b111 : 3'b000 and lower = 3'b001, row=5; then LAT=1 one cycle -> row_done one cycle later, last_row=5. Reads (x,5) give 111 for odd x and 000 for even x; reads (x,21) give 001 for all x.
- Full frame: rows 0..15, each pixel = {x[4],x[3],x[2]} -> frame_done pulses exactly once, after row 15. All 32 lines read back correctly; no len_err.
- Short row: 63 shifts then LAT, row=3 -> len_err pulses; lines 3 and 19 keep prior contents; row_done stays 0.
- Long row: 70 shifts then LAT -> len_err pulses, no write, ovf cleared afterwards. The next correct 64-shift row commits normally.
- Abort and reset: 30 shifts then OE=0/LAT=0 -> abort pulses. Then 40 shifts, rst low 1 cycle, then a full row 7 -> only row 7 is written, with no stale columns.
- Read latency and out-of-range: rd_y=40 -> rd_rgb=0. A read of line r in the commit cycle returns old data, and the next cycle returns new data.
